dmem_responder: RTL and testbench

//  Data-memory responder: the memory side of the processor's dmem request/ack bus.

---
 rtl/simple_processor_pkg.sv | 16 +
 rtl/dmem_array.sv | 23 ++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/simple_processor_pkg.sv
// Shared constants and types for the simple_processor data-memory path.
// Bus widths, dmem depth/latency defaults and the responder state type.
package simple_processor_pkg;

  localparam int ADDR_WIDTH   = 16;
  localparam int DATA_WIDTH   = 16;
  localparam int DMEM_DEPTH   = 64;
  localparam int DMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    DMEM_IDLE,
    DMEM_WAIT,
    DMEM_RESP
  } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// Word storage for dmem_responder: DEPTH x DW, no reset.
// Ports: clk_i, we_i (sync write), addr_i (word index), wdata_i, rdata_o (comb read).
module dmem_array #(
  parameter int DEPTH = 64,
  parameter int DW    = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [IW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dmem_responder.sv
// Memory side of the dmem req/ack bus: one access at a time, fixed latency, 1-cycle ack.
// Ports: clk_i, arst_ni, dmem_req_i/we_i/addr_i/wdata_i in; dmem_rdata_o, dmem_ack_o out.
// Build option DMEM_RDATA_HOLD_EN: rdata holds the last read value between read acks.
module dmem_responder
  import simple_processor_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = ADDR_WIDTH,
  parameter int MEM_DATA_WIDTH = DATA_WIDTH,
  parameter int DEPTH          = DMEM_DEPTH,
  parameter int LATENCY        = DMEM_LATENCY
) (
  input  logic                      clk_i,
  input  logic                      arst_ni,
  input  logic                      dmem_req_i,
  input  logic                      dmem_we_i,
  input  logic [MEM_ADDR_WIDTH-1:0] dmem_addr_i,
  input  logic [MEM_DATA_WIDTH-1:0] dmem_wdata_i,
  output logic [MEM_DATA_WIDTH-1:0] dmem_rdata_o,
  output logic                      dmem_ack_o
);

  localparam int IW = $clog2(DEPTH);
  localparam int CW = 4;

  dmem_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lat_en;

  logic                      we_q;
  logic [MEM_ADDR_WIDTH-1:0] addr_q;
  logic [MEM_DATA_WIDTH-1:0] wdata_q;

  logic                      ack_q;
  logic                      rd_ack_q;
  logic [MEM_DATA_WIDTH-1:0] rd_q;

  logic                      resp;
  logic [IW-1:0]             idx;
  logic [MEM_DATA_WIDTH-1:0] mem_rdata;
  logic                      unused_addr;

  assign idx         = addr_q[IW:1];
  assign unused_addr = ^{addr_q[MEM_ADDR_WIDTH-1:IW+1], addr_q[0]};
  assign resp        = (state_q == DMEM_RESP);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_en  = 1'b0;
    unique case (state_q)
      DMEM_IDLE: begin
        if (dmem_req_i) begin
          lat_en = 1'b1;
          if (LATENCY == 1) begin
            state_d = DMEM_RESP;
          end else begin
            state_d = DMEM_WAIT;
            cnt_d   = CW'(LATENCY - 1);
          end
        end
      end
      DMEM_WAIT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = DMEM_RESP;
      end
      DMEM_RESP: state_d = DMEM_IDLE;
      default:   state_d = DMEM_IDLE;
    endcase
  end

  // ack and read data register off the RESP cycle, so the ack cycle
  // is already IDLE and a held req is taken at its closing edge.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      state_q  <= DMEM_IDLE;
      cnt_q    <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      ack_q    <= 1'b0;
      rd_ack_q <= 1'b0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ack_q    <= resp;
      rd_ack_q <= resp & ~we_q;
      if (lat_en) begin
        we_q    <= dmem_we_i;
        addr_q  <= dmem_addr_i;
        wdata_q <= dmem_wdata_i;
      end
      if (resp && !we_q) rd_q <= mem_rdata;
    end
  end

  dmem_array #(
    .DEPTH(DEPTH),
    .DW   (MEM_DATA_WIDTH)
  ) u_array (
    .clk_i  (clk_i),
    .we_i   (resp & we_q),
    .addr_i (idx),
    .wdata_i(wdata_q),
    .rdata_o(mem_rdata)
  );

  assign dmem_ack_o = ack_q;

`ifdef DMEM_RDATA_HOLD_EN
  assign dmem_rdata_o = rd_q;
`else
  assign dmem_rdata_o = rd_ack_q ? rd_q : '0;
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: LATENCY=2 and LATENCY=1 instances.
// Driver pushes expected acks; a negedge monitor pops and compares.
module tb_dmem_responder;
  import simple_processor_pkg::*;

  localparam int AW    = ADDR_WIDTH;
  localparam int DW    = DATA_WIDTH;
  localparam int DEPTH = DMEM_DEPTH;
  localparam int L0    = 2;
  localparam int L1    = 1;
`ifdef DMEM_RDATA_HOLD_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  typedef struct {
    int            cyc;
    bit            we;
    logic [DW-1:0] data;
  } exp_t;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic          req   [2];
  logic          we    [2];
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rdata [2];
  logic          ack   [2];

  exp_t          q0[$];
  exp_t          q1[$];
  logic [DW-1:0] hold [2];
  int            acks [2];
  int            cyc = 0;
  int            errors = 0;
  int            checks = 0;

  dmem_responder #(.LATENCY(L0)) u_dut0 (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .dmem_req_i  (req[0]),
    .dmem_we_i   (we[0]),
    .dmem_addr_i (addr[0]),
    .dmem_wdata_i(wdata[0]),
    .dmem_rdata_o(rdata[0]),
    .dmem_ack_o  (ack[0])
  );

  dmem_responder #(.LATENCY(L1)) u_dut1 (
    .clk_i       (clk),
    .arst_ni     (arst_n),
    .dmem_req_i  (req[1]),
    .dmem_we_i   (we[1]),
    .dmem_addr_i (addr[1]),
    .dmem_wdata_i(wdata[1]),
    .dmem_rdata_o(rdata[1]),
    .dmem_ack_o  (ack[1])
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic on_ack(input int d);
    exp_t e;
    logic [DW-1:0] ex;
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      chk($sformatf("unexpected_ack%0d", d), 32'(ack[d]), 32'd0);
      return;
    end
    if (d == 0) e = q0.pop_front();
    else e = q1.pop_front();
    chk($sformatf("ack_cycle%0d", d), cyc, e.cyc);
    ex = e.we ? (HOLD ? hold[d] : '0) : e.data;
    chk($sformatf("ack_rdata%0d", d), 32'(rdata[d]), 32'(ex));
    if (!e.we) hold[d] = e.data;
    acks[d]++;
  endtask

  always @(negedge clk) begin
    if (arst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (ack[d]) on_ack(d);
        else chk($sformatf("idle_rdata%0d", d), 32'(rdata[d]),
                 32'(HOLD ? hold[d] : '0));
      end
    end
  end

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic wait_ack(input int d, input int target, input int budget);
    for (int i = 0; i < budget && acks[d] < target; i++) begin
      @(negedge clk);
      #1;
    end
    if (acks[d] < target) chk($sformatf("ack_timeout%0d", d), acks[d], target);
  endtask

  task automatic txn(input int d, input bit w, input logic [AW-1:0] a,
                     input logic [DW-1:0] wd, input logic [DW-1:0] exp_rd);
    exp_t e;
    int n0;
    n0 = acks[d];
    req[d] = 1'b1; we[d] = w; addr[d] = a; wdata[d] = wd;
    @(posedge clk);
    #1;
    e.cyc = cyc + (d == 0 ? L0 : L1);
    e.we = w;
    e.data = exp_rd;
    push(d, e);
    req[d] = 1'b0;
    wait_ack(d, n0 + 1, 10);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    exp_t e;
    int   n0;
    for (int d = 0; d < 2; d++) begin
      req[d] = 1'b0; we[d] = 1'b0; addr[d] = '0; wdata[d] = '0;
      hold[d] = '0; acks[d] = 0;
    end
    arst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ack0", 32'(ack[0]), 0);
    chk("reset_rdata0", 32'(rdata[0]), 0);
    chk("reset_ack1", 32'(ack[1]), 0);
    chk("reset_rdata1", 32'(rdata[1]), 0);
    arst_n = 1'b1;
    @(negedge clk);
    #1;

    txn(0, 1, 16'h0010, 16'hBEEF, 16'h0);
    txn(0, 0, 16'h0010, 16'h0, 16'hBEEF);

    txn(0, 1, 16'h0002, 16'h1234, 16'h0);
    txn(0, 0, 16'(2 + DEPTH * 2), 16'h0, 16'h1234);
    txn(0, 0, 16'h0003, 16'h0, 16'h1234);

    txn(0, 1, 16'h0008, 16'h0808, 16'h0);
    n0 = acks[0];
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0004; wdata[0] = 16'hAAAA;
    @(posedge clk);
    #1;
    e.cyc = cyc + L0; e.we = 1'b1; e.data = '0;
    push(0, e);
    req[0] = 1'b0; we[0] = 1'b0; addr[0] = 16'h0008; wdata[0] = 16'h5A5A;
    wait_ack(0, n0 + 1, 10);
    txn(0, 0, 16'h0004, 16'h0, 16'hAAAA);
    txn(0, 0, 16'h0008, 16'h0, 16'h0808);

    txn(0, 1, 16'h0006, 16'h1111, 16'h0);
    req[0] = 1'b1; we[0] = 1'b1; addr[0] = 16'h0006; wdata[0] = 16'h5555;
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    req[0] = 1'b0;
    hold[0] = '0;
    hold[1] = '0;
    #1;
    chk("midreset_ack0", 32'(ack[0]), 0);
    chk("midreset_rdata0", 32'(rdata[0]), 0);
    repeat (3) @(posedge clk);
    #1;
    chk("inreset_ack0", 32'(ack[0]), 0);
    arst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    txn(0, 0, 16'h0006, 16'h0, 16'h1111);

    txn(0, 1, 16'h000A, 16'h00FF, 16'h0);
    txn(0, 0, 16'h000A, 16'h0, 16'h00FF);
    txn(0, 1, 16'h000C, 16'h7777, 16'h0);
    repeat (5) @(negedge clk);
    #1;

    txn(1, 1, 16'h0020, 16'h4321, 16'h0);
    n0 = acks[1];
    req[1] = 1'b1; we[1] = 1'b0; addr[1] = 16'h0020;
    @(posedge clk);
    #1;
    e.cyc = cyc + 1; e.we = 1'b0; e.data = 16'h4321;
    push(1, e);
    e.cyc = cyc + 3;
    push(1, e);
    repeat (2) @(posedge clk);
    #1;
    req[1] = 1'b0;
    wait_ack(1, n0 + 2, 10);

    repeat (4) @(negedge clk);
    #1;
    chk("queue0_drained", q0.size(), 0);
    chk("queue1_drained", q1.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
